tse_pcs_config_sequencer: RTL and testbench
===========================================

# tse_pcs_config_sequencer

Register-interface master that configures the Triple-Speed Ethernet SGMII PCS after reset and then monitors it. It sits beside the SGMII-to-GMII converter and drives its reg_addr/reg_data_in/reg_rd/reg_wr port, which is otherwise tied off, on the 125 MHz ref_clock domain. It programs the link timer and SGMII interface mode, issues a PCS soft reset with auto-negotiation enabled, and polls status. Its status outputs drive the board LEDs and gate fpga_core traffic.

## Interface
- LINK_TIMER, 200000: SGMII link timer in ref_clock ticks (1.6 ms at 125 MHz); 21 bits used.
- IF_MODE, 16'h0003: if_mode register value (SGMII_ENA=1, USE_SGMII_AN=1).
- PCS_CONTROL, 16'h1140: control value written with bit 15 OR'd in (AN enable, full-duplex, 1000).
- POLL_INTERVAL, 125000: idle cycles between status reads (1 ms).
- BUSY_TIMEOUT, 1023: max cycles a single access may wait on busy.
- i_clock, in, 1: ref_clock, 125 MHz; the only clock.
- i_reset, in, 1: synchronous, active-high reset.
- o_reg_addr, out, 5: PCS register address.
- o_reg_data, out, 16: write data (to reg_data_in).
- o_reg_wr, out, 1: write strobe.
- o_reg_rd, out, 1: read strobe.
- i_reg_data, in, 16: read data (from reg_data_out).
- i_reg_busy, in, 1: access in progress.
- o_config_done, out, 1: init writes finished and soft reset self-cleared.
- o_link_up, out, 1: last status read had bit 2 = 1.
- o_an_complete, out, 1: last status read had bit 5 = 1.
- o_error, out, 1: sticky; an access exceeded BUSY_TIMEOUT.

## Operation
- Init list, in order: 0x12 <- LINK_TIMER[15:0]; 0x13 <- {11'b0, LINK_TIMER[20:16]}; 0x14 <- IF_MODE; 0x00 <- PCS_CONTROL | 16'h8000.
- FSM states and transitions:
  - INIT_WR: issue the indexed write; on completion, advance the index. After the 4th write, go to RST_RD.
  - RST_RD: read 0x00. If bit 15 = 1, re-read immediately. If bit 15 = 0, set o_config_done and go to POLL_WAIT.
  - POLL_WAIT: count POLL_INTERVAL cycles, then go to POLL_RD.
  - POLL_RD: read 0x01, update o_link_up and o_an_complete, then go to POLL_WAIT.
  - ERROR: terminal. o_error = 1, no strobes. Left only by i_reset.
- Access handshake:
  - Address, data and strobe assert together and stay stable until completion.
  - Completion is the first cycle with a strobe asserted and i_reg_busy = 0. The first strobe cycle counts, so zero-wait slaves complete in 1 cycle.
  - Read data is sampled on the completion cycle.
  - The strobe deasserts the cycle after completion.
  - At least one idle cycle separates consecutive accesses.
  - Never both strobes at once.
- Timeout:
  - A per-access counter starts at 0 on strobe assertion.
  - If it reaches BUSY_TIMEOUT with busy still high: drop the strobe, set o_error, go to ERROR.
- Link loss: o_link_up follows each poll; no re-initialisation on link drop.

## Timing
- Reset values:
  - All outputs 0; o_reg_addr = 0, o_reg_data = 0.
  - FSM in INIT_WR with index 0; counters cleared.
- First write strobe is asserted in the 1st cycle after i_reset deasserts.
- With busy never asserted:
  - Each access = 1 strobe cycle + 1 gap cycle.
  - o_config_done rises 10 cycles after reset release: 8 cycles of writes, then 1 strobe cycle + 1 gap cycle for a single RST_RD that returns bit15 = 0.
- Status flags update on the cycle after the read completion cycle.
- i_reset mid-access: the strobe drops on the next edge with no completion; the sequence restarts from write 0.
- Poll counter width: $clog2(POLL_INTERVAL+1). Timeout counter width: $clog2(BUSY_TIMEOUT+1).

## Structure
- Package tse_pcs_pkg holds:
  - register address constants (CONTROL=0x00, STATUS=0x01, LINK_TIMER_LO=0x12, LINK_TIMER_HI=0x13, IF_MODE=0x14);
  - status bit indices (LINK=2, AN_DONE=5);
  - the FSM state enum.
- One sub-module, tse_reg_master: owns the single-access strobe/busy/timeout handshake. It exposes a req/we/addr/wdata → done/rdata/timeout interface to the sequencer FSM.

## Test plan
- Zero-wait slave model, status = 0x0024:
  - writes appear exactly as 0x12=0x0D40, 0x13=0x0003, 0x14=0x0003, 0x00=0x9140;
  - o_config_done at cycle 10;
  - o_link_up = o_an_complete = 1 after the first poll.
- Busy held 3 cycles per access: each strobe is 4 cycles long with stable addr/data; the init order is unchanged.
- Control read returns 0x9140 twice, then 0x1140: exactly 3 reads of 0x00, and o_config_done asserts only after the third.
- Busy stuck high on write 2 (BUSY_TIMEOUT=15):
  - strobe drops after 15 cycles, o_error = 1;
  - no further strobes for 1000 cycles;
  - i_reset clears everything and restarts.
- Status 0x0024, then 0x0000 on the next poll: o_link_up goes 1→0 one cycle after the second read completes; no re-init writes.
- i_reset asserted during the 3rd write with busy high:
  - o_reg_wr = 0 the next cycle;
  - after release, the write sequence restarts at 0x12.

Source files
------------

// File: rtl/tse_pcs_pkg.sv
// Shared definitions for the TSE SGMII PCS configuration sequencer:
// register map, status bit positions, FSM state type and init-list lookup.
package tse_pcs_pkg;

  localparam logic [4:0] REG_CONTROL       = 5'h00;
  localparam logic [4:0] REG_STATUS        = 5'h01;
  localparam logic [4:0] REG_LINK_TIMER_LO = 5'h12;
  localparam logic [4:0] REG_LINK_TIMER_HI = 5'h13;
  localparam logic [4:0] REG_IF_MODE       = 5'h14;

  localparam int STAT_LINK      = 2;
  localparam int STAT_AN_DONE   = 5;
  localparam int CTRL_RESET_BIT = 15;

  localparam logic [1:0] INIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT_WR   = 3'd0,
    ST_RST_RD    = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_POLL_RD   = 3'd3,
    ST_ERROR     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } reg_access_t;

  // Address/data of the idx-th init write; the last one also sets the
  // control soft-reset bit so the PCS restarts with the new settings.
  function automatic reg_access_t init_access(input logic [1:0]  idx,
                                              input logic [20:0] link_timer,
                                              input logic [15:0] if_mode,
                                              input logic [15:0] control);
    reg_access_t acc;
    case (idx)
      2'd0: begin
        acc.addr = REG_LINK_TIMER_LO;
        acc.data = link_timer[15:0];
      end
      2'd1: begin
        acc.addr = REG_LINK_TIMER_HI;
        acc.data = {11'b0, link_timer[20:16]};
      end
      2'd2: begin
        acc.addr = REG_IF_MODE;
        acc.data = if_mode;
      end
      2'd3: begin
        acc.addr = REG_CONTROL;
        acc.data = control | 16'h8000;
      end
      default: begin
        acc.addr = REG_CONTROL;
        acc.data = 16'h0000;
      end
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/tse_reg_master.sv
// Single-access master for the PCS register port. Launches one read or
// write per request, holds address/data/strobe stable until the slave
// drops busy, and abandons the access after BUSY_TIMEOUT busy cycles.
module tse_reg_master import tse_pcs_pkg::*; #(
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rdata,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  input  logic        reg_busy
);

  localparam int              TW     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0]   TLIMIT = TW'(BUSY_TIMEOUT);
  localparam logic [TW-1:0]   TONE   = TW'(1);

  logic          active;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] wait_next;

  // Completion and timeout are decided on the edge that ends a strobe
  // cycle, so both are combinational views of the current strobe cycle.
  assign active    = reg_wr | reg_rd;
  assign wait_next = wait_cnt + TONE;
  assign done      = active & ~reg_busy;
  assign timeout   = active & reg_busy & (wait_next == TLIMIT);
  assign rdata     = reg_rdata;

  // Strobe/address/data launch, hold and release; the idle state after a
  // completion gives the mandatory gap cycle between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      reg_addr <= 5'h00;
      reg_data <= 16'h0000;
      wait_cnt <= '0;
    end else if (!active) begin
      if (req) begin
        reg_wr   <= we;
        reg_rd   <= ~we;
        reg_addr <= addr;
        reg_data <= wdata;
        wait_cnt <= '0;
      end
    end else if (done || timeout) begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_next;
    end
  end

endmodule

// File: rtl/tse_pcs_config_sequencer.sv
// Configures the TSE SGMII PCS after reset (link timer, if_mode, control
// with soft reset + AN enable), waits for the soft reset to self-clear,
// then polls the status register and reports link / AN state.
module tse_pcs_config_sequencer import tse_pcs_pkg::*; #(
  parameter logic [20:0] LINK_TIMER    = 21'd200000,
  parameter logic [15:0] IF_MODE       = 16'h0003,
  parameter logic [15:0] PCS_CONTROL   = 16'h1140,
  parameter int          POLL_INTERVAL = 125000,
  parameter int          BUSY_TIMEOUT  = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [4:0]  o_reg_addr,
  output logic [15:0] o_reg_data,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  input  logic [15:0] i_reg_data,
  input  logic        i_reg_busy,
  output logic        o_config_done,
  output logic        o_link_up,
  output logic        o_an_complete,
  output logic        o_error
);

  localparam int            PW    = $clog2(POLL_INTERVAL + 1);
  localparam logic [PW-1:0] PLAST = PW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  seq_state_t    state;
  logic [1:0]    init_idx;
  logic [PW-1:0] poll_cnt;

  reg_access_t   init_acc;
  logic          req;
  logic          we;
  logic [4:0]    addr;
  logic [15:0]   wdata;
  logic          done;
  logic          timeout;
  logic [15:0]   rdata;
  logic          unused_rdata;

  // Bits of the read word the sequencer does not interpret.
  assign unused_rdata = ^{rdata[14:6], rdata[4:3], rdata[1:0]};

  // Request presented to the access master for the current state.
  always_comb begin
    init_acc = init_access(init_idx, LINK_TIMER, IF_MODE, PCS_CONTROL);
    req      = 1'b0;
    we       = 1'b0;
    addr     = REG_CONTROL;
    wdata    = 16'h0000;
    case (state)
      ST_INIT_WR: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = init_acc.addr;
        wdata = init_acc.data;
      end
      ST_RST_RD: begin
        req  = 1'b1;
        addr = REG_CONTROL;
      end
      ST_POLL_RD: begin
        req  = 1'b1;
        addr = REG_STATUS;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  tse_reg_master #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_master (
    .clk      (i_clock),
    .rst      (i_reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .done     (done),
    .timeout  (timeout),
    .rdata    (rdata),
    .reg_addr (o_reg_addr),
    .reg_data (o_reg_data),
    .reg_wr   (o_reg_wr),
    .reg_rd   (o_reg_rd),
    .reg_rdata(i_reg_data),
    .reg_busy (i_reg_busy)
  );

  // Sequencer FSM: init writes, soft-reset wait, periodic status polling,
  // and a terminal error state entered on any access timeout.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_INIT_WR;
      init_idx      <= 2'd0;
      poll_cnt      <= '0;
      o_config_done <= 1'b0;
      o_link_up     <= 1'b0;
      o_an_complete <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      case (state)
        ST_INIT_WR: begin
          if (timeout) begin
            state   <= ST_ERROR;
            o_error <= 1'b1;
          end else if (done) begin
            if (init_idx == INIT_LAST) begin
              state <= ST_RST_RD;
            end else begin
              init_idx <= init_idx + 2'd1;
            end
          end
        end
        ST_RST_RD: begin
          if (timeout) begin
            state   <= ST_ERROR;
            o_error <= 1'b1;
          end else if (done && !rdata[CTRL_RESET_BIT]) begin
            o_config_done <= 1'b1;
            poll_cnt      <= '0;
            state         <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (poll_cnt == PLAST) begin
            poll_cnt <= '0;
            state    <= ST_POLL_RD;
          end else begin
            poll_cnt <= poll_cnt + PONE;
          end
        end
        ST_POLL_RD: begin
          if (timeout) begin
            state   <= ST_ERROR;
            o_error <= 1'b1;
          end else if (done) begin
            o_link_up     <= rdata[STAT_LINK];
            o_an_complete <= rdata[STAT_AN_DONE];
            poll_cnt      <= '0;
            state         <= ST_POLL_WAIT;
          end
        end
        ST_ERROR: begin
          o_error <= 1'b1;
        end
        default: begin
          state   <= ST_ERROR;
          o_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tse_pcs_config_sequencer.sv
// Self-checking bench for tse_pcs_config_sequencer: a reactive PCS slave
// model logs every access; table-driven init/poll scenarios plus directed
// sequences for timeout, link loss and reset during an access.
module tb_tse_pcs_config_sequencer;

  localparam int POLL = 20;
  localparam int BTO  = 15;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [4:0]  o_reg_addr;
  logic [15:0] o_reg_data;
  logic        o_reg_wr;
  logic        o_reg_rd;
  logic [15:0] i_reg_data = 16'h0000;
  logic        i_reg_busy = 1'b0;
  logic        o_config_done;
  logic        o_link_up;
  logic        o_an_complete;
  logic        o_error;

  tse_pcs_config_sequencer #(
    .POLL_INTERVAL(POLL),
    .BUSY_TIMEOUT (BTO)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .o_reg_addr   (o_reg_addr),
    .o_reg_data   (o_reg_data),
    .o_reg_wr     (o_reg_wr),
    .o_reg_rd     (o_reg_rd),
    .i_reg_data   (i_reg_data),
    .i_reg_busy   (i_reg_busy),
    .o_config_done(o_config_done),
    .o_link_up    (o_link_up),
    .o_an_complete(o_an_complete),
    .o_error      (o_error)
  );

  always #5 i_clock = ~i_clock;

  // slave configuration (written by the test only)
  int          busy_cycles = 0;
  int          ctrl_set    = 0;
  int          stuck_idx   = -1;
  logic [15:0] status_val  = 16'h0000;

  // slave state and access log (written by the model only)
  logic [4:0]  log_addr[64];
  logic [15:0] log_data[64];
  logic        log_wr[64];
  int          log_len[64];
  int          log_n       = 0;
  int          acc_n       = 0;
  int          busy_left   = 0;
  int          ctrl_left   = 0;
  int          unstable    = 0;
  int          both_cnt    = 0;
  logic        prev_strobe = 1'b0;
  logic [15:0] rd_val      = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  // Reactive PCS slave: busy pattern, read data and access logging.
  initial begin
    logic strobe;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        log_n       = 0;
        acc_n       = 0;
        busy_left   = 0;
        ctrl_left   = ctrl_set;
        prev_strobe = 1'b0;
        i_reg_busy  = 1'b0;
        i_reg_data  = 16'h0000;
      end else begin
        strobe = o_reg_wr | o_reg_rd;
        if (o_reg_wr && o_reg_rd) both_cnt++;
        if (strobe && !prev_strobe) begin
          busy_left = (acc_n == stuck_idx) ? 1000000 : busy_cycles;
          if (o_reg_rd && o_reg_addr == 5'h00) begin
            if (ctrl_left > 0) begin
              rd_val = 16'h9140;
              ctrl_left--;
            end else begin
              rd_val = 16'h1140;
            end
          end else if (o_reg_rd) begin
            rd_val = status_val;
          end else begin
            rd_val = 16'h0000;
          end
          if (log_n < 64) begin
            log_addr[log_n] = o_reg_addr;
            log_data[log_n] = o_reg_data;
            log_wr[log_n]   = o_reg_wr;
            log_len[log_n]  = 0;
          end
          log_n++;
          acc_n++;
        end else if (strobe && log_n > 0 && log_n <= 64) begin
          if (o_reg_addr !== log_addr[log_n-1] || o_reg_data !== log_data[log_n-1] ||
              o_reg_wr !== log_wr[log_n-1])
            unstable++;
        end
        if (strobe) begin
          if (log_n > 0 && log_n <= 64) log_len[log_n-1]++;
          if (busy_left > 0) begin
            i_reg_busy = 1'b1;
            busy_left--;
          end else begin
            i_reg_busy = 1'b0;
          end
          i_reg_data = rd_val;
        end else begin
          i_reg_busy = 1'b0;
          i_reg_data = 16'h0000;
        end
        prev_strobe = strobe;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    check("reset_state",
          {o_reg_wr, o_reg_rd, o_reg_addr, o_reg_data, o_config_done, o_link_up, o_an_complete, o_error},
          32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  typedef struct {
    int          busy;
    int          cset;
    logic [15:0] status;
    int          exp_done;
    logic        exp_link;
    logic        exp_an;
  } vec_t;

  vec_t        vecs[4];
  logic [4:0]  init_a[4];
  logic [15:0] init_d[4];

  initial begin
    int k;
    int nw;
    int strobes;

    init_a[0] = 5'h12; init_d[0] = 16'h0D40;
    init_a[1] = 5'h13; init_d[1] = 16'h0003;
    init_a[2] = 5'h14; init_d[2] = 16'h0003;
    init_a[3] = 5'h00; init_d[3] = 16'h9140;

    // done cycle = (4 writes + cset+1 reads) * (busy+1 strobe + 1 gap)
    vecs[0] = '{busy: 0, cset: 0, status: 16'h0024, exp_done: 10, exp_link: 1'b1, exp_an: 1'b1};
    vecs[1] = '{busy: 3, cset: 0, status: 16'h0004, exp_done: 25, exp_link: 1'b1, exp_an: 1'b0};
    vecs[2] = '{busy: 0, cset: 2, status: 16'h0020, exp_done: 14, exp_link: 1'b0, exp_an: 1'b1};
    vecs[3] = '{busy: 1, cset: 1, status: 16'hFFDB, exp_done: 18, exp_link: 1'b0, exp_an: 1'b0};

    for (int v = 0; v < 4; v++) begin
      busy_cycles = vecs[v].busy;
      ctrl_set    = vecs[v].cset;
      status_val  = vecs[v].status;
      stuck_idx   = -1;
      apply_reset();
      k = 0;
      while (!o_config_done && k < 400) begin
        step();
        k++;
      end
      check("done_cycle", k, vecs[v].exp_done);
      check("access_count", log_n, 5 + vecs[v].cset);
      for (int i = 0; i < 4; i++) begin
        check("init_addr", log_addr[i], init_a[i]);
        check("init_data", log_data[i], init_d[i]);
        check("init_is_wr", log_wr[i], 1'b1);
        check("init_len", log_len[i], vecs[v].busy + 1);
      end
      for (int i = 4; i < 5 + vecs[v].cset; i++) begin
        check("ctrl_rd_addr", log_addr[i], 5'h00);
        check("ctrl_rd_is_rd", log_wr[i], 1'b0);
        check("ctrl_rd_len", log_len[i], vecs[v].busy + 1);
      end
      k = 0;
      while (!o_reg_rd && k < 200) begin
        step();
        k++;
      end
      check("poll_delay", k, POLL + 1);
      check("poll_addr", o_reg_addr, 5'h01);
      k = 0;
      while (o_reg_rd && k < 50) begin
        step();
        k++;
      end
      check("poll_link", o_link_up, vecs[v].exp_link);
      check("poll_an", o_an_complete, vecs[v].exp_an);
      check("hold_stable", unstable, 0);
      check("no_dual_strobe", both_cnt, 0);
      check("no_error", o_error, 1'b0);
    end

    // Access timeout on the second write with busy stuck high.
    busy_cycles = 0;
    ctrl_set    = 0;
    status_val  = 16'h0024;
    stuck_idx   = 1;
    apply_reset();
    k = 0;
    while (log_n < 2 && k < 50) begin
      step();
      k++;
    end
    k = 0;
    while (o_reg_wr && k < 100) begin
      step();
      k++;
    end
    check("to_strobe_len", log_len[1], BTO);
    check("to_addr", log_addr[1], 5'h13);
    check("to_error", o_error, 1'b1);
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (o_reg_wr || o_reg_rd) strobes++;
    end
    check("to_no_strobes", strobes, 0);
    check("to_no_access", log_n, 2);
    check("to_error_sticky", o_error, 1'b1);
    check("to_not_done", o_config_done, 1'b0);
    stuck_idx = -1;
    apply_reset();
    step();
    check("to_restart_wr", o_reg_wr, 1'b1);
    check("to_restart_addr", o_reg_addr, 5'h12);
    check("to_error_clear", o_error, 1'b0);

    // Link loss between two polls: no re-initialisation.
    busy_cycles = 0;
    ctrl_set    = 0;
    status_val  = 16'h0024;
    apply_reset();
    k = 0;
    while (log_n < 6 && k < 200) begin
      step();
      k++;
    end
    k = 0;
    while (o_reg_rd && k < 50) begin
      step();
      k++;
    end
    check("ll_link_first", o_link_up, 1'b1);
    status_val = 16'h0000;
    k = 0;
    while (!o_reg_rd && k < 200) begin
      step();
      k++;
    end
    check("ll_second_poll_addr", o_reg_addr, 5'h01);
    check("ll_link_hold", o_link_up, 1'b1);
    step();
    check("ll_link_drop", o_link_up, 1'b0);
    check("ll_an_drop", o_an_complete, 1'b0);
    check("ll_done_kept", o_config_done, 1'b1);
    repeat (5) step();
    nw = 0;
    for (int i = 0; i < log_n && i < 64; i++) if (log_wr[i]) nw++;
    check("ll_no_reinit", nw, 4);

    // Reset asserted during the third write while the slave is busy.
    busy_cycles = 5;
    apply_reset();
    k = 0;
    while (log_n < 3 && k < 100) begin
      step();
      k++;
    end
    check("mr_in_write3", {o_reg_wr, o_reg_addr}, {1'b1, 5'h14});
    @(negedge i_clock);
    i_reset = 1'b1;
    step();
    check("mr_strobe_drop", {o_reg_wr, o_reg_rd}, 2'b00);
    @(negedge i_clock);
    i_reset = 1'b0;
    step();
    check("mr_restart_wr", o_reg_wr, 1'b1);
    check("mr_restart_addr", o_reg_addr, 5'h12);
    check("mr_restart_data", o_reg_data, 16'h0D40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
